// File: rtl/hazard_unit.sv
// Load-use stall and operand-forwarding detector for the 3-bit register core.
// Optional saturating hazard statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       rs1,
  input  logic [2:0]       rs2,
  input  logic [2:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [2:0]       mem_rd,
  input  logic             mem_reg_write,
  output logic             stall,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  logic       ex_live;
  logic       mem_live;
  logic       stall_raw;
  logic [2:0] rs_sel  [2];
  logic [1:0] fwd_sel [2];
  logic [1:0] ex_hit;
  logic [1:0] mem_hit;

  // A destination of register 0 never produces a value worth matching.
  assign ex_live  = ex_reg_write && (ex_rd != 3'd0);
  assign mem_live = mem_reg_write && (mem_rd != 3'd0);

  assign stall_raw = ex_live && ex_mem_read && ((ex_rd == rs1) || (ex_rd == rs2));
  assign stall     = rst_n && stall_raw;

  assign rs_sel[0] = rs1;
  assign rs_sel[1] = rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign ex_hit[gi]  = ex_live && (ex_rd == rs_sel[gi]);
      assign mem_hit[gi] = mem_live && (mem_rd == rs_sel[gi]);

      // EX is the youngest producer, so it wins over MEM.
      always_comb begin
        fwd_sel[gi] = FWD_RF;
        if (rst_n && !stall_raw) begin
          if (ex_hit[gi]) begin
            fwd_sel[gi] = FWD_EX;
          end else if (mem_hit[gi]) begin
            fwd_sel[gi] = FWD_MEM;
          end
        end
      end
    end
  endgenerate

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;
  logic             fwd_any;

  assign fwd_any = (forward_a != FWD_RF) || (forward_b != FWD_RF);

  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (!rst_n) begin
      stall_count_d = '0;
      fwd_count_d   = '0;
    end else begin
      if (stall && !(&stall_count_q)) begin
        stall_count_d = stall_count_q + 1'b1;
      end
      if (fwd_any && !(&fwd_count_q)) begin
        fwd_count_d = fwd_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    stall_count_q <= stall_count_d;
    fwd_count_q   <= fwd_count_d;
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`else
  // Without statistics the block is purely combinational and has no use for the clock.
  logic unused_clk;
  logic [31:0] unused_cnt_w;
  assign unused_clk   = clk;
  assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; counter checks are built with HAZARD_STATS_EN.
module tb_hazard_unit;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       rs1, rs2, ex_rd, mem_rd;
  logic             ex_reg_write, ex_mem_read, mem_reg_write;
  logic             stall;
  logic [1:0]       forward_a, forward_b;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count, fwd_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1           (rs1),
    .rs2           (rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .stall         (stall),
    .forward_a     (forward_a),
    .forward_b     (forward_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count   (stall_count),
    .fwd_count     (fwd_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] erd,
                       input logic ew, input logic em, input logic [2:0] mrd, input logic mw);
    rs1 = a; rs2 = b; ex_rd = erd; ex_reg_write = ew; ex_mem_read = em;
    mem_rd = mrd; mem_reg_write = mw;
  endtask

  // Drives one vector at the falling edge; the following rising edge counts it.
  task automatic apply(input string tag, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] erd, input logic ew, input logic em,
                       input logic [2:0] mrd, input logic mw,
                       input logic exp_s, input logic [1:0] exp_fa, input logic [1:0] exp_fb);
    @(negedge clk);
    drive(a, b, erd, ew, em, mrd, mw);
    #1;
    $display("vec %s: stall=%0b fa=%b fb=%b", tag, stall, forward_a, forward_b);
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_s});
    check({tag, ".fa"}, {30'd0, forward_a}, {30'd0, exp_fa});
    check({tag, ".fb"}, {30'd0, forward_b}, {30'd0, exp_fb});
  endtask

  // Idles the inputs at the falling edge so no further counting happens, then reads counters.
  task automatic check_counts(input string tag, input int exp_s, input int exp_f);
    @(negedge clk);
    drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
`ifdef HAZARD_STATS_EN
    $display("cnt %s: stall_count=%0d fwd_count=%0d", tag, stall_count, fwd_count);
    check({tag, ".stall_count"}, {28'd0, stall_count}, exp_s);
    check({tag, ".fwd_count"}, {28'd0, fwd_count}, exp_f);
`else
    $display("cnt %s: statistics not built (expected %0d/%0d)", tag, exp_s, exp_f);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset gating: hazards present, outputs must stay quiet.
    apply("rst_loaduse", 3'd1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    apply("rst_fwd",     3'd1, 3'd2, 3'd2, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_counts("after_reset", 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    apply("no_hazard",   3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 2'b00, 2'b00);
    apply("load_use_a",  3'd1, 3'd2, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 2'b00, 2'b00);
    apply("mem_fwd_a",   3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'b01, 2'b00);
    apply("ex_priority", 3'd2, 3'd2, 3'd2, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'b10, 2'b10);
    apply("reg_zero",    3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    apply("mixed_fwd",   3'd5, 3'd6, 3'd6, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 2'b01, 2'b10);
    apply("load_nowr",   3'd1, 3'd2, 3'd1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 2'b01, 2'b00);
    apply("load_use_b",  3'd3, 3'd4, 3'd4, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 2'b00, 2'b00);
    apply("ex_nowr",     3'd1, 3'd2, 3'd1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 2'b00, 2'b00);
    apply("mem_zero",    3'd0, 3'd7, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    check_counts("mixed_run", 2, 4);

    // Clear, hold a stall for three cycles, then reset mid-stall.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply("hold_stall", 3'd6, 3'd1, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 2'b00, 2'b00);
    end
    check_counts("before_rst", 3, 0);
    rst_n = 1'b0;
    apply("rst_midrun",  3'd6, 3'd1, 3'd6, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_counts("after_rst", 0, 0);

    // Saturation of the 4-bit counter.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply("sat_stall", 3'd2, 3'd5, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 2'b00, 2'b00);
    end
    check_counts("saturated", 15, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
